instr_fetch: RTL and testbench

Instruction fetch stage for the single-cycle MIPS core, directly upstream of the control decoder. It holds the PC, fetches each instruction over a variable-latency req/ack instruction-memory interface, and presents the registered instruction with its OpCode/funct fields to the decoder. It then selects the next PC from the decoder's jump/branch outcome (sequential, branch target or jump target) when the datapath signals completion.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/instr_fetch_npc.sv | 39 +++
 rtl/instr_fetch.sv | 89 ++++++++
 tb/tb_instr_fetch.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch slice:
// instruction field positions, default reset PC and fetch states.
package mips_pkg;

   localparam int OPC_HI   = 31;
   localparam int OPC_LO   = 26;
   localparam int FUNCT_HI = 5;
   localparam int FUNCT_LO = 0;
   localparam int IMM_HI   = 15;
   localparam int IMM_LO   = 0;
   localparam int JIDX_HI  = 25;
   localparam int JIDX_LO  = 0;

   localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;

   typedef enum logic [1:0] {
      ST_RESET,
      ST_FETCH,
      ST_ISSUE
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch_npc.sv
// Next-PC selection: jump target, taken branch or sequential,
// in that priority order. Purely combinational.
module npc
   import mips_pkg::*;
(
   input  logic [31:0] pc_plus4,
   input  logic [31:0] instr,
   input  logic        jump,
   input  logic        branch,
   input  logic        zero,
   output logic [31:0] next_pc
);

   logic [31:0] boff;
   logic [31:0] btgt;
   logic [31:0] jtgt;
   logic [31:0] sel;
   logic        unused_bits;

   assign boff = {{14{instr[IMM_HI]}},
                  instr[IMM_HI:IMM_LO], 2'b00};
   assign btgt = pc_plus4 + boff;
   assign jtgt = {pc_plus4[31:28],
                  instr[JIDX_HI:JIDX_LO], 2'b00};

   always_comb begin
      sel = pc_plus4;
      priority case (1'b1)
         jump:          sel = jtgt;
         branch & zero: sel = btgt;
         default:       sel = pc_plus4;
      endcase
   end

   assign next_pc = {sel[31:2], 2'b00};

   assign unused_bits = ^{instr[31:26], sel[1:0]};

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: holds PC, fetches over req/ack memory, presents
// the registered instruction to the decoder, retires on exec_done.
module instr_fetch
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_ack,
   input  logic [31:0]      imem_rdata,
   output logic [31:0]      instr,
   output logic [5:0]       opcode,
   output logic [5:0]       funct,
   output logic [15:0]      imm16,
   output logic             instr_valid,
   output logic [31:0]      pc,
   output logic [31:0]      pc_plus4,
   input  logic             jump,
   input  logic             branch,
   input  logic             zero,
   input  logic             exec_done,
   output logic [CNT_W-1:0] retired
);

   localparam logic [31:0] PC0 = {RESET_PC[31:2], 2'b00};

   fetch_state_t state;
   logic [31:0]  next_pc;

   assign imem_addr = pc;
   assign pc_plus4  = pc + 32'd4;
   assign opcode    = instr[OPC_HI:OPC_LO];
   assign funct     = instr[FUNCT_HI:FUNCT_LO];
   assign imm16     = instr[IMM_HI:IMM_LO];

   npc u_npc (
      .pc_plus4 (pc_plus4),
      .instr    (instr),
      .jump     (jump),
      .branch   (branch),
      .zero     (zero),
      .next_pc  (next_pc)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_RESET;
         pc          <= PC0;
         instr       <= '0;
         instr_valid <= 1'b0;
         imem_req    <= 1'b0;
         retired     <= '0;
      end else begin
         unique case (state)
            ST_RESET: begin
               state    <= ST_FETCH;
               imem_req <= 1'b1;
            end
            ST_FETCH: begin
               if (imem_ack) begin
                  instr       <= imem_rdata;
                  state       <= ST_ISSUE;
                  imem_req    <= 1'b0;
                  instr_valid <= 1'b1;
               end
            end
            ST_ISSUE: begin
               if (exec_done) begin
                  pc          <= next_pc;
                  retired     <= retired + CNT_W'(1);
                  state       <= ST_FETCH;
                  imem_req    <= 1'b1;
                  instr_valid <= 1'b0;
               end
            end
            default: begin
               state       <= ST_RESET;
               imem_req    <= 1'b0;
               instr_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: phase-level reference model checked
// every cycle, plus directed fetch/retire scenarios.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        jump = 1'b0;
   logic        branch = 1'b0;
   logic        zero = 1'b0;
   logic        exec_done = 1'b0;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [15:0] imm16;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] retired;

   always #5 clk = ~clk;

   instr_fetch #(
      .RESET_PC (32'h0000_3000),
      .CNT_W    (32)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .opcode      (opcode),
      .funct       (funct),
      .imm16       (imm16),
      .instr_valid (instr_valid),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .jump        (jump),
      .branch      (branch),
      .zero        (zero),
      .exec_done   (exec_done),
      .retired     (retired)
   );

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   // model: 0 = held in reset, 1 = fetching, 2 = instr issued
   int          m_ph = 0;
   logic [31:0] m_pc = 32'h3000;
   logic [31:0] m_instr = 32'h0;
   logic [31:0] m_ret = 32'h0;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h @%0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_npc(
      input logic [31:0] p,
      input logic [31:0] ins,
      input logic j, b, z);
      logic [31:0] s;
      int o;
      s = p + 32'd4;
      o = $signed(ins[15:0]);
      o = o * 4;
      if (j) return {s[31:28], ins[25:0], 2'b00};
      if (b && z) return s + 32'(o);
      return s;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_ph = 0;
         m_pc = 32'h3000;
         m_instr = 32'h0;
         m_ret = 32'h0;
      end else if (m_ph == 0) begin
         m_ph = 1;
      end else if (m_ph == 1) begin
         if (imem_ack) begin
            m_instr = imem_rdata;
            m_ph = 2;
         end
      end else if (exec_done) begin
         m_pc = ref_npc(m_pc, m_instr, jump, branch, zero);
         m_ret = m_ret + 32'd1;
         m_ph = 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_req", 32'(imem_req), 32'(m_ph == 1));
         chk("m_valid", 32'(instr_valid), 32'(m_ph == 2));
         chk("m_addr", imem_addr, m_pc);
         chk("m_pc", pc, m_pc);
         chk("m_pc4", pc_plus4, m_pc + 32'd4);
         chk("m_instr", instr, m_instr);
         chk("m_opc", 32'(opcode), 32'(m_instr[31:26]));
         chk("m_funct", 32'(funct), 32'(m_instr[5:0]));
         chk("m_imm", 32'(imm16), 32'(m_instr[15:0]));
         chk("m_ret", retired, m_ret);
      end
   end

   task automatic fetch(input logic [31:0] ea,
                        input int w,
                        input logic [31:0] word,
                        input bit noise);
      int n;
      n = 0;
      imem_ack = 1'b0;
      while (!imem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("req_seen", 32'(imem_req), 32'd1);
      chk("fetch_addr", imem_addr, ea);
      if (noise) {exec_done, jump, branch, zero} = 4'hF;
      for (int i = 0; i < w; i++) begin
         @(negedge clk);
         chk("req_hold", 32'(imem_req), 32'd1);
         chk("addr_hold", imem_addr, ea);
      end
      imem_ack = 1'b1;
      imem_rdata = word;
      @(negedge clk);
      imem_ack = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      {exec_done, jump, branch, zero} = 4'h0;
      chk("valid_rise", 32'(instr_valid), 32'd1);
      chk("req_fall", 32'(imem_req), 32'd0);
      chk("instr_word", instr, word);
      chk("pc_held", pc, ea);
   endtask

   task automatic issue(input logic j, b, z,
                        input int d,
                        input logic [31:0] eret);
      for (int i = 0; i < d; i++) begin
         imem_ack = 1'b1;
         imem_rdata = 32'hFFFF_FFFF;
         @(negedge clk);
      end
      imem_ack = 1'b0;
      {jump, branch, zero} = {j, b, z};
      exec_done = 1'b1;
      @(negedge clk);
      {exec_done, jump, branch, zero} = 4'h0;
      chk("retired", retired, eret);
      chk("valid_fall", 32'(instr_valid), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: no finish, limit %0d", 100000);
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      chk("rst_pc", pc, 32'h0000_3000);
      chk("rst_instr", instr, 32'h0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_ret", retired, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("req_after_rst", 32'(imem_req), 32'd1);

      fetch(32'h3000, 0, 32'h0000_0020, 1'b0);
      issue(1'b0, 1'b0, 1'b0, 0, 32'd1);
      fetch(32'h3004, 0, 32'h0000_0022, 1'b0);
      issue(1'b0, 1'b0, 1'b0, 0, 32'd2);
      fetch(32'h3008, 0, 32'h0000_0024, 1'b0);
      issue(1'b0, 1'b0, 1'b0, 0, 32'd3);

      fetch(32'h300C, 3, 32'h8C22_0004, 1'b0);
      chk("lw_opc", 32'(opcode), 32'h23);
      chk("lw_funct", 32'(funct), 32'h04);
      chk("lw_imm", 32'(imm16), 32'h0004);
      issue(1'b0, 1'b0, 1'b0, 2, 32'd4);

      fetch(32'h3010, 2, 32'h1000_FFFC, 1'b1);
      issue(1'b0, 1'b1, 1'b1, 0, 32'd5);
      fetch(32'h3004, 0, 32'h0800_0C04, 1'b0);
      issue(1'b1, 1'b0, 1'b0, 0, 32'd6);
      fetch(32'h3010, 0, 32'h1000_FFFC, 1'b0);
      issue(1'b0, 1'b1, 1'b0, 0, 32'd7);
      fetch(32'h3014, 0, 32'h0800_0C08, 1'b0);
      issue(1'b1, 1'b0, 1'b0, 0, 32'd8);
      fetch(32'h3020, 1, 32'h0800_0C10, 1'b0);
      issue(1'b1, 1'b1, 1'b1, 0, 32'd9);
      fetch(32'h3040, 0, 32'h0800_0000, 1'b0);
      issue(1'b1, 1'b0, 1'b0, 0, 32'd10);

      fetch(32'h0000_0000, 0, 32'h1000_FFFE, 1'b0);
      issue(1'b0, 1'b1, 1'b1, 0, 32'd11);
      fetch(32'hFFFF_FFFC, 0, 32'h0000_0000, 1'b1);
      chk("wrap_pc4", pc_plus4, 32'h0);
      issue(1'b0, 1'b0, 1'b0, 0, 32'd12);
      fetch(32'h0000_0000, 0, 32'h0000_0020, 1'b0);
      issue(1'b0, 1'b0, 1'b0, 0, 32'd13);

      chk("mid_req", 32'(imem_req), 32'd1);
      chk("mid_addr", imem_addr, 32'h0000_0004);
      @(negedge clk);
      rst_n = 1'b0;
      imem_ack = 1'b1;
      imem_rdata = 32'h1234_5678;
      @(negedge clk);
      chk("rst_req_drop", 32'(imem_req), 32'd0);
      chk("rst_pc_again", pc, 32'h0000_3000);
      chk("rst_ret_again", retired, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("stale_instr", instr, 32'h0);
      chk("stale_valid", 32'(instr_valid), 32'd0);
      fetch(32'h3000, 0, 32'h2108_0001, 1'b0);
      issue(1'b0, 1'b0, 1'b0, 0, 32'd1);
      fetch(32'h3004, 0, 32'h0000_0020, 1'b0);

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
